hazard_ctrl: RTL and testbench

Pipeline hazard controller that drives the stall and clear inputs of the IF/ID and ID/EX pipeline registers and the PC hold. It detects load-use hazards between the ID and EX stages, flushes younger instructions on a taken branch or jump resolved in EX, and freezes the whole front end while data memory is busy. It contains a small FSM with a cycle counter for multi-cycle stalls and flushes, plus saturating performance counters.

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and memory-busy
// freezes for the IF/ID and ID/EX registers, with saturating event counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             redirect_ex,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_clr,
  output logic             idex_stall,
  output logic             idex_clr,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0]    LOAD_RELOAD  = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0]    FLUSH_RELOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  typedef enum logic [1:0] {S_RUN, S_LOAD_STALL, S_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             stall_inc, flush_inc;

  assign lu = mem_read_ex && (rd_ex != 5'd0) &&
              ((use_rs1_id && (rs1_id == rd_ex)) || (use_rs2_id && (rs2_id == rd_ex)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Priority: reset, then memory freeze, then redirect, then load-use.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_clr   = 1'b0;
    idex_stall = 1'b0;
    idex_clr   = 1'b0;

    if (clr) begin
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (mem_busy) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
    end else begin
      unique case (state_q)
        S_RUN, S_LOAD_STALL: begin
          if (redirect_ex) begin
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = S_FLUSH;
              cnt_d   = FLUSH_RELOAD;
            end else begin
              state_d = S_RUN;
              cnt_d   = '0;
            end
          end else if (state_q == S_LOAD_STALL || lu) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_clr   = 1'b1;
            stall_inc  = 1'b1;
            if (state_q == S_LOAD_STALL) begin
              if (cnt_q <= CW'(1)) begin
                state_d = S_RUN;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q - CW'(1);
              end
            end else if (LOAD_LAT > 1) begin
              state_d = S_LOAD_STALL;
              cnt_d   = LOAD_RELOAD;
            end
          end
        end
        S_FLUSH: begin
          ifid_clr = 1'b1;
          idex_clr = 1'b1;
          if (redirect_ex) begin
            flush_inc = 1'b1;
            cnt_d     = FLUSH_RELOAD;
          end else if (cnt_q <= CW'(1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two configurations driven in lockstep and
// compared against a remaining-penalty model of the pipeline control rules.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic       use_rs1_id = 1'b0, use_rs2_id = 1'b0;
  logic       mem_read_ex = 1'b0, redirect_ex = 1'b0, mem_busy = 1'b0;

  logic        pc_a, ifs_a, ifc_a, ids_a, idc_a;
  logic        pc_b, ifs_b, ifc_b, ids_b, idc_b;
  logic [3:0]  sc_a, fc_a;
  logic [15:0] sc_b, fc_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_dut_a (
    .clk(clk), .clr(clr), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .redirect_ex(redirect_ex), .mem_busy(mem_busy),
    .pc_stall(pc_a), .ifid_stall(ifs_a), .ifid_clr(ifc_a), .idex_stall(ids_a),
    .idex_clr(idc_a), .stall_count(sc_a), .flush_count(fc_a));

  hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .clr(clr), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .redirect_ex(redirect_ex), .mem_busy(mem_busy),
    .pc_stall(pc_b), .ifid_stall(ifs_b), .ifid_clr(ifc_b), .idex_stall(ids_b),
    .idex_clr(idc_b), .stall_count(sc_b), .flush_count(fc_b));

  // Output vectors are {pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr}.
  localparam logic [4:0] CTL_IDLE  = 5'b00000;
  localparam logic [4:0] CTL_FREEZE = 5'b11010;
  localparam logic [4:0] CTL_FLUSH = 5'b00101;
  localparam logic [4:0] CTL_STALL = 5'b11001;

  int lat[2]  = '{3, 1};
  int fcy[2]  = '{2, 1};
  int cmax[2] = '{15, 65535};
  int stall_left[2], flush_left[2], m_sc[2], m_fc[2];

  logic [9:0]  obs_ctl, exp_ctl;
  logic [39:0] obs_cnt, exp_cnt;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = 0; flush_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  // Apply one cycle of inputs (called just after a rising edge); records the
  // observed/expected control outputs and the counters after the next edge.
  task automatic step(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                      input logic u2, input logic [4:0] rd, input logic mr,
                      input logic rdr, input logic busy);
    logic       hz;
    logic [4:0] e[2];
    rs1_id = r1; use_rs1_id = u1; rs2_id = r2; use_rs2_id = u2;
    rd_ex = rd; mem_read_ex = mr; redirect_ex = rdr; mem_busy = busy;
    hz = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
    @(negedge clk);
    obs_ctl = {pc_a, ifs_a, ifc_a, ids_a, idc_a, pc_b, ifs_b, ifc_b, ids_b, idc_b};
    for (int k = 0; k < 2; k++) begin
      if (busy) e[k] = CTL_FREEZE;
      else if (rdr) begin
        e[k] = CTL_FLUSH;
        if (m_fc[k] < cmax[k]) m_fc[k]++;
        flush_left[k] = fcy[k] - 1;
        stall_left[k] = 0;
      end else if (flush_left[k] > 0) begin
        e[k] = CTL_FLUSH;
        flush_left[k]--;
      end else if (stall_left[k] > 0 || hz) begin
        e[k] = CTL_STALL;
        if (m_sc[k] < cmax[k]) m_sc[k]++;
        stall_left[k] = (stall_left[k] > 0) ? stall_left[k] - 1 : lat[k] - 1;
      end else e[k] = CTL_IDLE;
    end
    exp_ctl = {e[0], e[1]};
    exp_cnt = {4'(m_sc[0]), 4'(m_fc[0]), 16'(m_sc[1]), 16'(m_fc[1])};
    @(posedge clk);
    #1;
    obs_cnt = {sc_a, fc_a, sc_b, fc_b};
  endtask

  task automatic idle();
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #1 clr = 1'b1;
    #1;
    n_checks++;
    if ({sc_a, fc_a, sc_b, fc_b} !== 40'd0) begin
      n_fail++; $display("FAIL reset_counters: got %h expected 0", {sc_a, fc_a, sc_b, fc_b});
    end
    n_checks++;
    if ({pc_a, ifs_a, ifc_a, ids_a, idc_a, pc_b, ifs_b, ifc_b, ids_b, idc_b} !== {CTL_FLUSH, CTL_FLUSH}) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected %b",
        {pc_a, ifs_a, ifc_a, ids_a, idc_a, pc_b, ifs_b, ifc_b, ids_b, idc_b}, {CTL_FLUSH, CTL_FLUSH});
    end
    @(posedge clk); #1 clr = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      idle();
      n_checks++;
      if (obs_ctl !== 10'd0) begin
        n_fail++; $display("FAIL idle_ctl: got %b expected %b", obs_ctl, 10'd0);
      end
    end
  endtask

  task automatic test_load_use();
    step(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_ctl !== {CTL_STALL, CTL_STALL} || sc_b !== 16'd1) begin
      n_fail++; $display("FAIL load_use_first: got %b sc_b=%0d expected %b sc_b=1", obs_ctl, sc_b, {CTL_STALL, CTL_STALL});
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      n_checks++;
      if (obs_ctl !== exp_ctl || obs_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL load_use_tail: got %b/%h expected %b/%h", obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
    end
    n_checks++;
    if (sc_a !== 4'd3) begin
      n_fail++; $display("FAIL load_use_penalty: got %0d expected 3", sc_a);
    end
  endtask

  task automatic test_no_stall();
    step(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_ctl !== 10'd0 || obs_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL x0_no_stall: got %b/%h expected 0/%h", obs_ctl, obs_cnt, exp_cnt);
    end
    step(5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_ctl !== 10'd0 || obs_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL unused_rs1: got %b/%h expected 0/%h", obs_ctl, obs_cnt, exp_cnt);
    end
  endtask

  task automatic test_redirect_vs_hazard();
    logic [3:0] sc_before;
    sc_before = sc_a;
    step(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs_ctl !== {CTL_FLUSH, CTL_FLUSH}) begin
      n_fail++; $display("FAIL redirect_first: got %b expected %b", obs_ctl, {CTL_FLUSH, CTL_FLUSH});
    end
    idle();
    n_checks++;
    if (obs_ctl !== {CTL_FLUSH, CTL_IDLE}) begin
      n_fail++; $display("FAIL redirect_second: got %b expected %b", obs_ctl, {CTL_FLUSH, CTL_IDLE});
    end
    idle();
    n_checks++;
    if (obs_ctl !== 10'd0 || fc_a !== 4'd1 || sc_a !== sc_before) begin
      n_fail++; $display("FAIL redirect_end: got %b fc=%0d sc=%0d expected 0 fc=1 sc=%0d", obs_ctl, fc_a, sc_a, sc_before);
    end
  endtask

  task automatic test_busy_mid_stall();
    logic [3:0] sc_before;
    sc_before = sc_a;
    step(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs_ctl !== {CTL_FREEZE, CTL_FREEZE} || obs_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL busy_freeze: got %b/%h expected %b/%h", obs_ctl, obs_cnt, {CTL_FREEZE, CTL_FREEZE}, exp_cnt);
      end
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      n_checks++;
      if (obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL busy_resume: got %b expected %b", obs_ctl, exp_ctl);
      end
    end
    n_checks++;
    if (sc_a !== 4'(sc_before + 4'd3)) begin
      n_fail++; $display("FAIL busy_stall_count: got %0d expected %0d", sc_a, 4'(sc_before + 4'd3));
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (fc_a !== 4'd15 || obs_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL flush_saturate: got fc_a=%0d cnt=%h expected 15 cnt=%h", fc_a, obs_cnt, exp_cnt);
    end
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (fc_a !== 4'd15) begin
      n_fail++; $display("FAIL flush_hold: got %0d expected 15", fc_a);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    step(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      n_checks++;
      if (obs_ctl !== exp_ctl || obs_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL back_to_back: got %b/%h expected %b/%h", obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(5'd2, 1'b0, 5'd2, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if ({sc_a, fc_a, sc_b, fc_b} !== 40'd0 ||
        {pc_a, ifs_a, ifc_a, ids_a, idc_a} !== CTL_FLUSH) begin
      n_fail++; $display("FAIL reset_mid_stall: got cnt=%h ctl=%b expected 0/%b",
        {sc_a, fc_a, sc_b, fc_b}, {pc_a, ifs_a, ifc_a, ids_a, idc_a}, CTL_FLUSH);
    end
    @(posedge clk); #1 clr = 1'b0;
    model_reset();
    idle();
    n_checks++;
    if (obs_ctl !== 10'd0 || obs_cnt !== 40'd0) begin
      n_fail++; $display("FAIL reset_mid_after: got %b/%h expected 0/0", obs_ctl, obs_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 6) == 0));
      n_checks++;
      if (obs_ctl !== exp_ctl || obs_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL random_cycle_%0d: got %b/%h expected %b/%h", i, obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect_vs_hazard();
    test_busy_mid_stall();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
